ids_multi_match: RTL and testbench

Parametrised successor to the single-pattern IDS stage in the NetFPGA user datapath. It sits between two pipeline modules and forwards packets with one cycle of latency. Each 64-bit payload word is compared against NUM_PATTERNS software-programmed patterns. Each pattern has its own saturating per-packet match counter, which the surrounding generic_regs wrapper exposes as a hardware register.

---
 rtl/ids_multi_match_pkg.sv | 11 +
 rtl/ids_pattern_cmp.sv | 46 ++++
 rtl/ids_multi_match.sv | 95 +++++++++
 tb/tb_ids_multi_match.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ids_multi_match_pkg.sv
// ids_multi_match_pkg: FSM state encodings, ids_cmd bit indices and saturating increment.
package ids_multi_match_pkg;
  typedef enum logic [1:0] {START = 2'b00, HEADER = 2'b01, PAYLOAD = 2'b10} state_t;
  localparam int IDS_CMD_CLR = 0;
  localparam int IDS_CMD_EN = 1;
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    return (v >= top) ? v : v + 64'd1;
  endfunction
endpackage

// File: rtl/ids_pattern_cmp.sv
// ids_pattern_cmp: one shadowed pattern, per-packet hit flag and saturating match counter.
// With IDS_MASK_EN defined a shadowed per-bit compare mask is added.
module ids_pattern_cmp
  import ids_multi_match_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] pattern,
`ifdef IDS_MASK_EN
  input  logic [DATA_WIDTH-1:0] mask,
`endif
  input  logic                  en,
  input  logic                  cmp,
  input  logic                  eop,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [CNT_WIDTH-1:0]  count
);
  logic [DATA_WIDTH-1:0] pat_q;
  logic hit_q, match, hit_pkt;
`ifdef IDS_MASK_EN
  logic [DATA_WIDTH-1:0] mask_q;
  assign match = ((word ^ pat_q) & mask_q) == '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) mask_q <= '0;
    else if (load) mask_q <= mask;
`else
  assign match = word == pat_q;
`endif
  // the last word is compared on the same edge that commits the packet
  assign hit_pkt = hit_q | (cmp & en & match);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pat_q <= '0;
      hit_q <= 1'b0;
      count <= '0;
    end else begin
      if (load) pat_q <= pattern;
      hit_q <= eop ? 1'b0 : hit_pkt;
      count <= clr ? '0 : (eop & hit_pkt) ? CNT_WIDTH'(sat_inc(64'(count), CNT_WIDTH)) : count;
    end
endmodule

// File: rtl/ids_multi_match.sv
// ids_multi_match: one-cycle pass-through stage counting per-packet payload matches against NUM_PATTERNS patterns.
// Define IDS_MASK_EN to add the per-pattern compare masks port.
module ids_multi_match
  import ids_multi_match_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_PATTERNS = 4,
  parameter int HEADER_WORDS = 3,
  parameter int CNT_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [DATA_WIDTH-1:0]            in_data,
  input  logic [CTRL_WIDTH-1:0]            in_ctrl,
  input  logic                             in_wr,
  output logic                             in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] patterns,
`ifdef IDS_MASK_EN
  input  logic [NUM_PATTERNS*DATA_WIDTH-1:0] masks,
`endif
  input  logic [31:0]                      ids_cmd,
  output logic [NUM_PATTERNS*CNT_WIDTH-1:0]  match_counts,
  output logic [CNT_WIDTH-1:0]             pkt_count
);
  localparam int HW = $clog2(HEADER_WORDS + 1);
  localparam logic [HW-1:0] HDR_LAST = HW'(HEADER_WORDS);
  localparam logic [HW-1:0] ONE = HW'(1);
  state_t st, st_nxt;
  logic [HW-1:0] hdr_cnt, hdr_nxt;
  logic acc, ctrl_z, load, cmp, eop, pkt_done, en_q, clr, unused_cmd;
  assign in_rdy = out_rdy;
  assign acc = in_wr & out_rdy;
  assign ctrl_z = in_ctrl == '0;
  assign clr = ids_cmd[IDS_CMD_CLR];
  assign unused_cmd = ^ids_cmd[31:2];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st <= START;
      hdr_cnt <= '0;
    end else begin
      st <= st_nxt;
      hdr_cnt <= hdr_nxt;
    end
  always_comb begin
    st_nxt = (st == START)   ? (load ? ((HEADER_WORDS == 1) ? PAYLOAD : HEADER) : START) :
             (st == HEADER)  ? (!acc ? HEADER : !ctrl_z ? START :
                                (hdr_cnt + ONE == HDR_LAST) ? PAYLOAD : HEADER) :
             (st == PAYLOAD) ? (eop ? START : PAYLOAD) : START;
    hdr_nxt = load ? ONE : (st == HEADER && acc && ctrl_z) ? hdr_cnt + ONE : hdr_cnt;
  end
  always_comb begin
    load = st == START && acc && ctrl_z;
    cmp = st == PAYLOAD && acc;
    eop = cmp && !ctrl_z;
    pkt_done = eop || (st == HEADER && acc && !ctrl_z);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out_wr <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
      en_q <= 1'b0;
      pkt_count <= '0;
    end else begin
      out_wr <= acc;
      if (acc) begin
        out_data <= in_data;
        out_ctrl <= in_ctrl;
      end
      if (load) en_q <= ids_cmd[IDS_CMD_EN];
      pkt_count <= clr ? '0 : pkt_done ? CNT_WIDTH'(sat_inc(64'(pkt_count), CNT_WIDTH)) : pkt_count;
    end
  for (genvar i = 0; i < NUM_PATTERNS; i++) begin : g_cmp
    ids_pattern_cmp #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_cmp (
      .clk(clk),
      .reset(reset),
      .load(load),
      .pattern(patterns[i*DATA_WIDTH +: DATA_WIDTH]),
`ifdef IDS_MASK_EN
      .mask(masks[i*DATA_WIDTH +: DATA_WIDTH]),
`endif
      .en(en_q),
      .cmp(cmp),
      .eop(eop),
      .clr(clr),
      .word(in_data),
      .count(match_counts[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule

// File: tb/tb_ids_multi_match.sv
// tb_ids_multi_match: directed tests of ids_multi_match with 4-bit counters; covers IDS_MASK_EN when defined.
module tb_ids_multi_match;
  localparam int DW = 64, CW = 8, NP = 4, CNTW = 4;
  localparam logic [63:0] P0 = 64'hDEADBEEF_CAFEF00D;
  localparam logic [63:0] P1 = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P2 = 64'h5555_6666_7777_8888;
  localparam logic [63:0] P3 = 64'h9999_AAAA_BBBB_CCCC;
  logic clk = 0, reset = 0, in_wr = 0, out_rdy = 1, in_rdy, out_wr;
  logic [DW-1:0] in_data = '0, out_data;
  logic [CW-1:0] in_ctrl = '0, out_ctrl;
  logic [NP*DW-1:0] patterns = {P3, P2, P1, P0};
  logic [31:0] ids_cmd = 32'd2;
  logic [NP*CNTW-1:0] match_counts;
  logic [CNTW-1:0] pkt_count;
`ifdef IDS_MASK_EN
  logic [NP*DW-1:0] masks = '1;
`endif
  int checks = 0, failures = 0;
  logic [63:0] td[8];
  logic [7:0] tc[8];
  logic [63:0] rx_d[$];
  logic [7:0] rx_c[$];
  logic [3:0] exp_mc[4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic [3:0] exp_pkt = 4'd0;

  ids_multi_match #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_PATTERNS(NP), .HEADER_WORDS(3), .CNT_WIDTH(CNTW)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy), .patterns(patterns),
`ifdef IDS_MASK_EN
    .masks(masks),
`endif
    .ids_cmd(ids_cmd), .match_counts(match_counts), .pkt_count(pkt_count));

  always #5 clk = ~clk;

  always @(negedge clk)
    if (out_wr) begin
      rx_d.push_back(out_data);
      rx_c.push_back(out_ctrl);
    end

  task automatic make_pkt(input logic [63:0] h2, pa, pb, pc, pd);
    td = '{64'h0A0A_0000_0000_0001, 64'h100, h2, 64'h300, pa, pb, pc, pd};
    tc = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80};
  endtask

  task automatic send_pkt(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      in_data = td[i];
      in_ctrl = tc[i];
      in_wr = 1;
      w = 0;
      do begin
        @(posedge clk);
        w++;
      end while (!out_rdy && w < 50);
      if (!out_rdy) begin
        failures++;
        $display("FAIL send_timeout word=%0d waited=%0d cycles", i, w);
      end
      #1;
    end
    in_wr = 0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_wr !== 1'b0 || out_data !== '0 || out_ctrl !== '0) begin failures++; $display("FAIL reset_out got wr=%b data=%h ctrl=%h exp 0", out_wr, out_data, out_ctrl); end
    checks++; if (match_counts !== '0 || pkt_count !== '0) begin failures++; $display("FAIL reset_cnt got mc=%h pkt=%h exp 0", match_counts, pkt_count); end
    checks++; if (in_rdy !== 1'b1) begin failures++; $display("FAIL rdy_high got=%b exp=1", in_rdy); end
    out_rdy = 0;
    #1;
    checks++; if (in_rdy !== 1'b0) begin failures++; $display("FAIL rdy_low got=%b exp=0", in_rdy); end
    out_rdy = 1;
    @(negedge clk) reset = 1;
    in_data = 64'h55; in_ctrl = 8'hFF; in_wr = 1;
    @(posedge clk);
    #1 in_wr = 0;
    #2 reset = 0;
    #1;
    checks++; if (out_wr !== 1'b0 || out_data !== '0) begin failures++; $display("FAIL async_reset got wr=%b data=%h exp 0", out_wr, out_data); end
    @(negedge clk) reset = 1;
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_basic();
    make_pkt(64'h200, 64'hA1, P0, 64'hA3, 64'hA4);
    @(negedge clk);
    in_data = td[0]; in_ctrl = tc[0]; in_wr = 1;
    #1;
    checks++; if (out_wr !== 1'b0) begin failures++; $display("FAIL basic_pre got wr=%b exp=0", out_wr); end
    for (int i = 0; i < 8; i++) begin
      in_data = td[i]; in_ctrl = tc[i]; in_wr = 1;
      @(posedge clk);
      #1;
      checks++;
      if (out_wr !== 1'b1 || out_data !== td[i] || out_ctrl !== tc[i]) begin
        failures++;
        $display("FAIL basic_fwd%0d got wr=%b data=%h ctrl=%h exp wr=1 data=%h ctrl=%h", i, out_wr, out_data, out_ctrl, td[i], tc[i]);
      end
    end
    in_wr = 0;
    @(posedge clk);
    #1;
    checks++; if (out_wr !== 1'b0) begin failures++; $display("FAIL basic_idle got wr=%b exp=0", out_wr); end
    exp_mc[0] = 1; exp_pkt = 1;
    for (int i = 0; i < NP; i++) begin
      checks++; if (match_counts[i*CNTW +: CNTW] !== exp_mc[i]) begin failures++; $display("FAIL basic_mc%0d got=%0d exp=%0d", i, match_counts[i*CNTW +: CNTW], exp_mc[i]); end
    end
    checks++; if (pkt_count !== exp_pkt) begin failures++; $display("FAIL basic_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_double();
    make_pkt(64'h200, P0, 64'hA2, P0, 64'hA4);
    send_pkt(8);
    @(negedge clk); #1;
    exp_mc[0] = 2; exp_pkt = 2;
    checks++; if (match_counts[3:0] !== exp_mc[0]) begin failures++; $display("FAIL double_mc0 got=%0d exp=%0d", match_counts[3:0], exp_mc[0]); end
    checks++; if (pkt_count !== exp_pkt) begin failures++; $display("FAIL double_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_header_only();
    make_pkt(P0, 64'hA1, 64'hA2, 64'hA3, 64'hA4);
    send_pkt(8);
    @(negedge clk); #1;
    exp_pkt = 3;
    checks++; if (match_counts[3:0] !== exp_mc[0]) begin failures++; $display("FAIL hdr_mc0 got=%0d exp=%0d", match_counts[3:0], exp_mc[0]); end
    checks++; if (pkt_count !== exp_pkt) begin failures++; $display("FAIL hdr_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_stall();
    make_pkt(64'h200, 64'hA1, 64'hA2, P0, 64'hA4);
    fork
      send_pkt(8);
      begin
        repeat (5) @(posedge clk);
        #2 out_rdy = 0;
        repeat (3) @(posedge clk);
        #2 out_rdy = 1;
      end
    join
    @(negedge clk); #1;
    checks++; if (rx_d.size() !== 8) begin failures++; $display("FAIL stall_len got=%0d exp=8", rx_d.size()); end
    for (int i = 0; i < 8 && i < rx_d.size(); i++) begin
      checks++;
      if (rx_d[i] !== td[i] || rx_c[i] !== tc[i]) begin
        failures++;
        $display("FAIL stall_word%0d got data=%h ctrl=%h exp data=%h ctrl=%h", i, rx_d[i], rx_c[i], td[i], tc[i]);
      end
    end
    exp_mc[0] = 3; exp_pkt = 4;
    for (int i = 0; i < NP; i++) begin
      checks++; if (match_counts[i*CNTW +: CNTW] !== exp_mc[i]) begin failures++; $display("FAIL stall_mc%0d got=%0d exp=%0d", i, match_counts[i*CNTW +: CNTW], exp_mc[i]); end
    end
    checks++; if (pkt_count !== exp_pkt) begin failures++; $display("FAIL stall_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_shadow();
    make_pkt(64'h200, 64'hA1, 64'hA2, 64'hA3, P0);
    fork
      send_pkt(8);
      begin
        repeat (3) @(posedge clk);
        #2 patterns[63:0] = '0;
      end
    join
    @(negedge clk); #1;
    exp_mc[0] = 4; exp_pkt = 5;
    checks++; if (match_counts[3:0] !== exp_mc[0]) begin failures++; $display("FAIL shadow_cur got=%0d exp=%0d", match_counts[3:0], exp_mc[0]); end
    send_pkt(8);
    @(negedge clk); #1;
    exp_pkt = 6;
    checks++; if (match_counts[3:0] !== exp_mc[0]) begin failures++; $display("FAIL shadow_next got=%0d exp=%0d", match_counts[3:0], exp_mc[0]); end
    patterns[63:0] = P0;
    ids_cmd = 32'd0;
    send_pkt(8);
    @(negedge clk); #1;
    ids_cmd = 32'd2;
    exp_pkt = 7;
    checks++; if (match_counts[3:0] !== exp_mc[0]) begin failures++; $display("FAIL disabled_mc0 got=%0d exp=%0d", match_counts[3:0], exp_mc[0]); end
    checks++; if (pkt_count !== exp_pkt) begin failures++; $display("FAIL shadow_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_short();
    td[0] = 64'h100; tc[0] = 8'h00;
    td[1] = P0;      tc[1] = 8'h80;
    send_pkt(2);
    @(negedge clk); #1;
    exp_pkt = 8;
    checks++; if (match_counts[3:0] !== exp_mc[0] || pkt_count !== exp_pkt) begin failures++; $display("FAIL short got mc0=%0d pkt=%0d exp mc0=%0d pkt=%0d", match_counts[3:0], pkt_count, exp_mc[0], exp_pkt); end
    make_pkt(64'h200, P0, 64'hA2, 64'hA3, 64'hA4);
    send_pkt(8);
    @(negedge clk); #1;
    exp_mc[0] = 5; exp_pkt = 9;
    checks++; if (match_counts[3:0] !== exp_mc[0] || pkt_count !== exp_pkt) begin failures++; $display("FAIL after_short got mc0=%0d pkt=%0d exp mc0=%0d pkt=%0d", match_counts[3:0], pkt_count, exp_mc[0], exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_saturate();
    @(negedge clk) ids_cmd = 32'd3;
    @(negedge clk) ids_cmd = 32'd2;
    #1;
    exp_mc[0] = 0; exp_pkt = 0;
    checks++; if (match_counts !== '0 || pkt_count !== '0) begin failures++; $display("FAIL clear got mc=%h pkt=%0d exp 0", match_counts, pkt_count); end
    td[0] = 64'h100; td[1] = 64'h200; td[2] = 64'h300; td[3] = P0;
    tc[0] = 8'h00;   tc[1] = 8'h00;   tc[2] = 8'h00;   tc[3] = 8'h80;
    for (int k = 0; k < 15; k++) send_pkt(4);
    @(negedge clk); #1;
    checks++; if (match_counts[3:0] !== 4'hF || pkt_count !== 4'hF) begin failures++; $display("FAIL count15 got mc0=%h pkt=%h exp F", match_counts[3:0], pkt_count); end
    send_pkt(4);
    @(negedge clk); #1;
    checks++; if (match_counts[3:0] !== 4'hF || pkt_count !== 4'hF) begin failures++; $display("FAIL sat_hold got mc0=%h pkt=%h exp F", match_counts[3:0], pkt_count); end
    send_pkt(3);
    in_data = P0; in_ctrl = 8'h80; in_wr = 1; ids_cmd = 32'd3;
    @(posedge clk);
    #1 in_wr = 0; ids_cmd = 32'd2;
    checks++; if (match_counts[3:0] !== 4'h0 || pkt_count !== 4'h0) begin failures++; $display("FAIL clr_wins got mc0=%h pkt=%h exp 0", match_counts[3:0], pkt_count); end
    send_pkt(4);
    @(negedge clk); #1;
    exp_mc[0] = 1; exp_pkt = 1;
    checks++; if (match_counts[3:0] !== exp_mc[0] || pkt_count !== exp_pkt) begin failures++; $display("FAIL post_clr got mc0=%0d pkt=%0d exp mc0=%0d pkt=%0d", match_counts[3:0], pkt_count, exp_mc[0], exp_pkt); end
    rx_d.delete(); rx_c.delete();
  endtask

  task automatic test_mask();
    patterns[127:64] = 64'h1234_5678_CAFEF00D;
`ifdef IDS_MASK_EN
    masks[127:64] = 64'h0000_0000_FFFF_FFFF;
    exp_mc[1] = 1;
`endif
    make_pkt(64'h200, 64'hA1, 64'hAAAA_AAAA_CAFEF00D, 64'hA3, 64'hA4);
    send_pkt(8);
    @(negedge clk); #1;
    exp_pkt = 2;
    for (int i = 0; i < NP; i++) begin
      checks++; if (match_counts[i*CNTW +: CNTW] !== exp_mc[i]) begin failures++; $display("FAIL mask_mc%0d got=%0d exp=%0d", i, match_counts[i*CNTW +: CNTW], exp_mc[i]); end
    end
    checks++; if (pkt_count !== exp_pkt) begin failures++; $display("FAIL mask_pkt got=%0d exp=%0d", pkt_count, exp_pkt); end
    patterns[127:64] = P1;
`ifdef IDS_MASK_EN
    masks[127:64] = '1;
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_double();
    test_header_only();
    test_stall();
    test_shadow();
    test_short();
    test_saturate();
    test_mask();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
